// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported backing memory between the instruction-fetch
// port and the data port. Each access is sequenced IDLE -> BUSY (RAM_LAT cycles) -> DONE,
// and DONE produces a one-cycle ready pulse on the owning port.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   if_req/if_addr              fetch request (held until if_ready) and address
//   if_rdata/if_ready           fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                   data request, write enable, address and write data
//   mem_rdata/mem_ready/
//   mem_fault                   read data, completion pulse, unallocated-address flag
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata         backing-memory interface
//
// Optional feature: define MEM_ARB_SEGCHECK_EN to check data-port addresses against
// the text, data and stack segments. An out-of-segment data access skips the memory
// and completes with mem_fault = 1. Without the macro, mem_fault is tied to 0.
module mem_arbiter #(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STREAK     = 4,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_0000,
  parameter logic [31:0] TEXT_TOP   = 32'h0000_03FF,
  parameter logic [31:0] DATA_BASE  = 32'h0000_0400,
  parameter logic [31:0] DATA_TOP   = 32'h0000_0401,
  parameter logic [31:0] STACK_BASE = 32'h007F_F000,
  parameter logic [31:0] STACK_TOP  = 32'h007F_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

`ifdef MEM_ARB_SEGCHECK_EN
  localparam bit SegCheck = 1'b1;
`else
  localparam bit SegCheck = 1'b0;
`endif

  localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int unsigned StrW = (STREAK > 0) ? $clog2(STREAK + 1) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(RAM_LAT - 1);
  localparam logic [StrW-1:0] StreakMax = StrW'(STREAK);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StrW-1:0] streak_q, streak_d;
  logic            owner_data_q, owner_data_d;  // 1 = data port owns the access
  logic            if_ready_q, if_ready_d;
  logic            mem_ready_q, mem_ready_d;
  logic            mem_fault_q, mem_fault_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic [31:0]     ram_addr_q, ram_addr_d;
  logic [31:0]     ram_wdata_q, ram_wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;

  logic seg_hit;
  logic grant_fetch;

  assign seg_hit = ((mem_addr >= TEXT_BASE)  && (mem_addr <= TEXT_TOP))  ||
                   ((mem_addr >= DATA_BASE)  && (mem_addr <= DATA_TOP))  ||
                   ((mem_addr >= STACK_BASE) && (mem_addr <= STACK_TOP));

  // Data has priority unless fetch has already waited out a full streak.
  assign grant_fetch = if_req && (!mem_req || (streak_q == StreakMax));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    owner_data_d = owner_data_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    mem_fault_d  = 1'b0;
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (if_req || mem_req) begin
          state_d  = StBusy;
          cnt_d    = '0;
          ram_en_d = 1'b1;
          if (grant_fetch) begin
            owner_data_d = 1'b0;
            streak_d     = '0;
            ram_we_d     = 1'b0;
            ram_addr_d   = if_addr;
            ram_wdata_d  = '0;
          end else begin
            owner_data_d = 1'b1;
            // Only count data grants that actually made fetch wait.
            if (if_req) begin
              streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            if (SegCheck && !seg_hit) begin
              // Unallocated address: never touch memory, complete immediately.
              state_d     = StDone;
              ram_en_d    = 1'b0;
              ram_we_d    = 1'b0;
              mem_ready_d = 1'b1;
              mem_fault_d = 1'b1;
              mem_rdata_d = 'x;
            end
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          cnt_d    = '0;
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          if (owner_data_q) begin
            mem_rdata_d = ram_rdata;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      StDone: begin
        // No grant here so a still-held request is not accepted twice.
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      streak_q     <= '0;
      owner_data_q <= 1'b0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      mem_fault_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      owner_data_q <= owner_data_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      mem_fault_q  <= mem_fault_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_fault = SegCheck ? mem_fault_q : 1'b0;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
